// File: rtl/rf_op_sequencer.sv
// Issue stage for the register-file/ALU block: runs a small loaded program,
// handshakes each op against rf_done and captures rda/rdb per instruction.
module rf_op_sequencer #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [33:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic [2:0]    rf_op,
    output logic [4:0]    rf_ra,
    output logic [4:0]    rf_rb,
    output logic [4:0]    rf_w,
    output logic [15:0]   rf_wd,
    output logic          rf_req,
    input  logic          rf_done,
    input  logic [15:0]   rf_rda,
    input  logic [15:0]   rf_rdb,
    output logic [15:0]   res_a,
    output logic [15:0]   res_b,
    output logic [AW-1:0] res_pc,
    output logic          res_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          err
);

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  w;
        logic [15:0] wd;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_HALT, S_ERR
    } state_t;

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT - 1);
    localparam logic [AW:0]   LMAX = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    instr_t        mem [DEPTH];
    instr_t        cur;
    logic [AW:0]   len;
    logic [AW:0]   len_in;
    logic [WW-1:0] wcnt;
    logic          idle_like, go, last, cap, timeout, issue_load;
    logic [AW-1:0] issue_idx;

    assign idle_like = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);
    assign go        = start && idle_like;
    assign len_in    = (prog_len > LMAX) ? LMAX : prog_len;
    assign last      = ({1'b0, pc} == (len - 1'b1));
    assign cap       = (state == S_WAIT_DONE) && rf_done;
    assign timeout   = (wcnt == WMAX);
    // Fields for the next op are latched on the edge entering ISSUE, so
    // rf_req and the bus are valid together during the ISSUE cycle.
    assign issue_load = (go && (len_in != '0)) || (cap && !last);
    assign issue_idx  = go ? '0 : pc + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; completion is checked before the watchdog
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALT, S_ERR:
                if (start) state_nx = (len_in == '0) ? S_HALT : S_ISSUE;
            S_ISSUE:
                state_nx = S_WAIT_ACK;
            S_WAIT_ACK:
                if (!rf_done)     state_nx = S_WAIT_DONE;
                else if (timeout) state_nx = S_ERR;
            S_WAIT_DONE:
                if (rf_done)      state_nx = last ? S_HALT : S_ISSUE;
                else if (timeout) state_nx = S_ERR;
            default:
                state_nx = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy   = 1'b0;
        halted = 1'b0;
        err    = 1'b0;
        rf_req = 1'b0;
        case (state)
            S_ISSUE:     begin busy = 1'b1; rf_req = 1'b1; end
            S_WAIT_ACK,
            S_WAIT_DONE: busy = 1'b1;
            S_HALT:      halted = 1'b1;
            S_ERR:       err = 1'b1;
            default:     ;
        endcase
    end

    // Program memory is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!rst && load_en && !busy && !start)
            mem[load_addr] <= instr_t'(load_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            len       <= '0;
            wcnt      <= '0;
            cur       <= '0;
            res_a     <= '0;
            res_b     <= '0;
            res_pc    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (go) begin
                pc  <= '0;
                len <= len_in;
            end
            if (state == S_ISSUE)
                wcnt <= '0;
            else if (state == S_WAIT_ACK || state == S_WAIT_DONE)
                wcnt <= wcnt + 1'b1;
            if (cap) begin
                res_a     <= rf_rda;
                res_b     <= rf_rdb;
                res_pc    <= pc;
                res_valid <= 1'b1;
                if (!last) pc <= pc + 1'b1;
            end
            if (issue_load)
                cur <= mem[issue_idx];
        end
    end

    assign rf_op = cur.op;
    assign rf_ra = cur.ra;
    assign rf_rb = cur.rb;
    assign rf_w  = cur.w;
    assign rf_wd = cur.wd;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer with a small behavioural register file.
module tb_rf_op_sequencer;
    localparam int DEPTH = 16, AW = 4, MAX_WAIT = 64;

    logic          clk = 1'b0;
    logic          rst, load_en, start, rf_done;
    logic [AW-1:0] load_addr;
    logic [33:0]   load_data;
    logic [AW:0]   prog_len;
    logic [2:0]    rf_op;
    logic [4:0]    rf_ra, rf_rb, rf_w;
    logic [15:0]   rf_wd, rf_rda, rf_rdb, res_a, res_b;
    logic          rf_req, res_valid, busy, halted, err;
    logic [AW-1:0] res_pc, pc;

    rf_op_sequencer #(.DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start),
        .rf_op(rf_op), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_w(rf_w), .rf_wd(rf_wd),
        .rf_req(rf_req), .rf_done(rf_done), .rf_rda(rf_rda), .rf_rdb(rf_rdb),
        .res_a(res_a), .res_b(res_b), .res_pc(res_pc), .res_valid(res_valid),
        .pc(pc), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pc;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0, bad = 0, req_cnt = 0;
    bit   stuck = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.pc = p; e.a = a; e.b = b;
        q.push_back(e);
    endtask

    // Monitor: every res_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rf_req === 1'b1) req_cnt++;
        if (res_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_res: res_pc=%0d res_a=%0h, none expected", res_pc, res_a);
            end else begin
                mon_e = q.pop_front();
                chk("res_pc", 32'(res_pc), 32'(mon_e.pc));
                chk("res_a", 32'(res_a), 32'(mon_e.a));
                chk("res_b", 32'(res_b), 32'(mon_e.b));
            end
        end
    end

    // Register-file model: accepts on rf_req, done low for two cycles
    initial begin
        logic [15:0] regs [32];
        logic [2:0]  m_op;
        logic [4:0]  m_ra, m_rb, m_w;
        logic [15:0] m_wd, sum;
        int          cnt;
        bit          active;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rf_done = 1'b1; rf_rda = '0; rf_rdb = '0;
        active = 1'b0; cnt = 0;
        forever begin
            @(negedge clk);
            if (active) begin
                cnt--;
                if (cnt == 0) begin
                    case (m_op)
                        3'b000: begin regs[m_w] = m_wd; rf_rda = m_wd; rf_rdb = regs[m_rb]; end
                        3'b101: begin
                            sum = regs[m_ra] + regs[m_rb];
                            regs[m_w] = sum; rf_rda = sum; rf_rdb = regs[m_rb];
                        end
                        default: begin rf_rda = regs[m_ra]; rf_rdb = regs[m_rb]; end
                    endcase
                    rf_done = 1'b1;
                    active  = 1'b0;
                end
            end else if (rf_req === 1'b1 && !stuck) begin
                m_op = rf_op; m_ra = rf_ra; m_rb = rf_rb; m_w = rf_w; m_wd = rf_wd;
                rf_done = 1'b0; cnt = 2; active = 1'b1;
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [2:0] op, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] w, input logic [15:0] wd);
        load_en = 1'b1; load_addr = a; load_data = {op, ra, rb, w, wd};
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW:0] n);
        start = 1'b1; prog_len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 400 && !(halted || err); i++) @(negedge clk);
        chk("run_finished", 32'(halted | err), 32'd1);
    endtask

    task automatic push_base();
        push(0, 16'd17, 16'd0);
        push(1, 16'd17, 16'd0);
        push(2, 16'd34, 16'd17);
    endtask

    initial begin
        int r0;
        rst = 1'b1; load_en = 1'b0; start = 1'b0;
        load_addr = '0; load_data = '0; prog_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_req", 32'(rf_req), 0);
        chk("rst_fields", {rf_op, rf_ra, rf_rb, rf_w, rf_wd[12:0]}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Base three-entry program
        load(0, 3'b000, 5'd0, 5'd0, 5'd1, 16'd17);
        load(1, 3'b001, 5'd1, 5'd0, 5'd0, 16'd0);
        load(2, 3'b101, 5'd1, 5'd1, 5'd4, 16'd0);
        push_base();
        pulse_start(3);
        wait_end();
        chk("t1_halted", 32'(halted), 1);
        chk("t1_pc", 32'(pc), 2);

        // Empty program halts at once with no issue
        r0 = req_cnt;
        pulse_start(0);
        chk("len0_halted", 32'(halted), 1);
        chk("len0_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        chk("len0_no_req", 32'(req_cnt - r0), 0);

        // Watchdog: register file never accepts
        stuck = 1'b1;
        pulse_start(3);
        for (int i = 0; i < 10 && rf_req !== 1'b1; i++) @(negedge clk);
        chk("wd_req_seen", 32'(rf_req), 1);
        repeat (MAX_WAIT) @(negedge clk);
        chk("wd_err_early", 32'(err), 0);
        @(negedge clk);
        chk("wd_err", 32'(err), 1);
        chk("wd_pc", 32'(pc), 0);
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        push_base();
        pulse_start(3);
        chk("wd_err_cleared", 32'(err), 0);
        wait_end();
        chk("wd_rerun_halted", 32'(halted), 1);

        // Reset while entry 1 is in WAIT_DONE
        push(0, 16'd17, 16'd0);
        pulse_start(3);
        for (int i = 0; i < 50 && !(res_valid === 1'b1 && res_pc == 0); i++) @(negedge clk);
        chk("rst_mid_cap0", 32'(res_valid), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_req", 32'(rf_req), 0);
        chk("rst_mid_fields", {rf_op, rf_ra, rf_rb, rf_w, rf_wd[12:0]}, 0);
        chk("rst_mid_pc", 32'(pc), 0);
        repeat (4) @(negedge clk);
        push_base();
        pulse_start(3);
        wait_end();
        chk("rst_rerun_pc", 32'(pc), 2);

        // Load and start while busy are both ignored
        push_base();
        pulse_start(3);
        load(0, 3'b000, 5'd0, 5'd0, 5'd1, 16'hFFF7);
        pulse_start(0);
        @(negedge clk);
        chk("mid_start_busy", 32'(busy), 1);
        wait_end();
        chk("mid_pc", 32'(pc), 2);
        chk("mid_err", 32'(err), 0);
        push_base();
        pulse_start(3);
        wait_end();

        // Full program with prog_len clamped to DEPTH; negative data verbatim
        for (int i = 0; i < DEPTH; i++)
            load(AW'(i), 3'b000, 5'd0, 5'd0, 5'd2, 16'h8000 + 16'(i));
        for (int i = 0; i < DEPTH; i++) push(i, 16'h8000 + 16'(i), 16'd0);
        pulse_start(5'd20);
        wait_end();
        chk("clamp_halted", 32'(halted), 1);
        chk("clamp_pc", 32'(pc), DEPTH - 1);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_op_sequencer.md
Name: rf_op_sequencer

Overview:
- Upstream issue stage for the 32x16 register-file/ALU interface block.
- Holds a small loadable program of register-file operations and issues them one at a time on the op/ra/rb/w/wd bus.
- Each operation is handshaked against the register file's done signal; returned rda/rdb are captured per instruction.
- A watchdog flags a register file that never completes an operation.

Parameters:
DEPTH, 16, number of program entries (power of 2)
AW, 4, program address width, log2(DEPTH)
MAX_WAIT, 64, cycles allowed from issue to completion before error

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load_en  input  1  write one program entry; accepted only when busy=0
load_addr  input  AW  program entry index
load_data  input  34  {op[33:31], ra[30:26], rb[25:21], w[20:16], wd[15:0]}
prog_len  input  AW+1  number of entries to run, 0..DEPTH; sampled on start
start  input  1  single-cycle pulse; run program from entry 0
rf_op  output  3  op code to register file
rf_ra  output  5  read address A
rf_rb  output  5  read address B
rf_w  output  5  write address
rf_wd  output  16  write data / shift amount (signed)
rf_req  output  1  one-cycle issue strobe
rf_done  input  1  register file done level (low while operating)
rf_rda  input  16  register file read port A (signed)
rf_rdb  input  16  register file read port B (signed)
res_a  output  16  captured rf_rda of last completed op
res_b  output  16  captured rf_rdb of last completed op
res_pc  output  AW  program index of captured result
res_valid  output  1  one-cycle pulse when res_* update
pc  output  AW  index of instruction in flight / last executed
busy  output  1  high in ISSUE, WAIT_ACK, WAIT_DONE
halted  output  1  high in HALT
err  output  1  high in ERR

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; all outputs 0.
  - Program memory is not cleared.
  - Dominates start and load_en in the same cycle.
  - Reset during an operation drops rf_req and zeroes the rf_* fields on that same edge. The register file is not aborted.
- Program load:
  - load_en=1 with busy=0 writes mem[load_addr]=load_data at the edge.
  - Writes are ignored while busy=1.
  - If load_en and start occur in the same cycle, the load is ignored.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, HALT, ERR.
- IDLE/HALT/ERR + start:
  - pc<=0, len<=prog_len.
  - len==0: go to HALT directly, no issue.
  - Otherwise go to ISSUE. Starting from HALT or ERR clears halted/err.
- ISSUE (1 cycle):
  - rf_op..rf_wd <= fields of mem[pc]; rf_req=1; wait counter<=0.
  - Next state WAIT_ACK.
  - rf_* fields hold stable from ISSUE until exit from WAIT_DONE.
- WAIT_ACK:
  - Wait for rf_done=0 (operation accepted), then go to WAIT_DONE.
- WAIT_DONE:
  - On rf_done=1: res_a<=rf_rda, res_b<=rf_rdb, res_pc<=pc, res_valid=1 for one cycle.
  - If pc==len-1, go to HALT.
  - Otherwise pc<=pc+1 and go to ISSUE. The next issue is exactly one cycle after capture.
- Watchdog:
  - Counter increments every cycle in WAIT_ACK and WAIT_DONE.
  - When the counter reaches MAX_WAIT-1 without the pending transition, go to ERR. pc holds the failing index; no res_valid.
  - Completion wins if rf_done rises on the same cycle the counter expires.
- Outputs and inputs:
  - res_* values are not signed-extended or modified, captured verbatim.
  - start while busy=1 is ignored.
  - pc wraps never: len ≤ DEPTH guarantees pc ≤ DEPTH-1.
  - prog_len > DEPTH is clamped to DEPTH.
- HALT and ERR are sticky until start or rst.

Test Plan:
- Load 3 entries {000,w=1,wd=17}, {001,ra=1}, {101,ra=1,rb=1,w=4}; prog_len=3; start; behavioural register-file model -> three res_valid pulses:
  - res_pc=0 with res_a=17.
  - res_pc=1 with res_a=17.
  - res_pc=2 with res_a=34.
  - Then halted=1 and pc=2.
- prog_len=0, start -> halted=1 next cycle, rf_req never asserted, res_valid never asserted.
- Model holds rf_done=1 forever after issue -> err=1 exactly MAX_WAIT cycles after WAIT_ACK entry, pc=0, no res_valid.
  - A following start with a working model clears err and runs normally.
- rst=1 while in WAIT_DONE of entry 1:
  - Next edge: busy=0, rf_req=0, rf_* =0, pc=0.
  - Program memory is intact; a rerun gives identical results.
- load_en during busy writes wd=-9 to entry 0 -> ignored; a rerun still yields res_a=17 for entry 0.
- start pulsed again mid-run -> ignored; pc sequence remains 0,1,2 with one res_valid per entry.
